param_shift_reg: RTL
====================

PARAM_SHIFT_REG -- requirements
Module: param_shift_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data register width (>= 2).
REQ-002 SHALL have parameter AMT_W, default 4, width of the multi-shift amount.
REQ-003 SHALL have parameter SAT, default 0; 0 = wrap-around inc/dec, 1 = saturating inc/dec.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have ports cl, ld, inc, dec  input  1 each  clear, load, increment, decrement.
REQ-007 SHALL have port in  input  WIDTH  load data.
REQ-008 SHALL have ports sr, ir, sl, il  input  1 each  shift right and its MSB fill bit, shift left and its LSB fill bit.
REQ-009 SHALL have port ms_start  input  1  start multi-cycle shift.
REQ-010 SHALL have port ms_dir  input  1  0 = right, 1 = left.
REQ-011 SHALL have port ms_mode  input  2  00 logical (zero fill), 01 arithmetic (right: MSB replicated; left: zero fill), 10 rotate, 11 treated as 00.
REQ-012 SHALL have port ms_amt  input  AMT_W  number of single-bit shifts.
REQ-013 SHALL have port out  output  WIDTH  register contents.
REQ-014 SHALL have port carry  output  1  registered carry/borrow/shifted-out bit.
REQ-015 SHALL have port zero  output  1  combinational, 1 when out == 0.
REQ-016 SHALL have ports busy, done  output  1 each  multi-shift in progress; one-cycle completion pulse.

Function
REQ-017 SHALL implement FSM states IDLE, SHIFT, DONE; busy = (state==SHIFT), done = (state==DONE), both decoded from registered state.
REQ-018 In IDLE or DONE, SHALL apply at most one command per edge, priority cl > ld > inc > dec > sr > sl > ms_start; no command holds out and carry.
REQ-019 cl: out <= 0, carry <= 0. ld: out <= in, carry <= 0.
REQ-020 inc, SAT=0: out <= out+1 mod 2^WIDTH; carry <= 1 iff out was all-ones, else 0.
REQ-021 inc, SAT=1: out all-ones -> out held, carry <= 1; otherwise out+1, carry <= 0.
REQ-022 dec is the mirror of inc: wrap or hold at 0; carry <= 1 iff out was 0.
REQ-023 sr: out <= {ir, out[WIDTH-1:1]}, carry <= out[0]; sl: out <= {out[WIDTH-2:0], il}, carry <= out[WIDTH-1].
REQ-024 ms_start with ms_amt != 0: SHALL latch ms_dir, ms_mode, ms_amt into internal registers, leave out and carry unchanged, and go to SHIFT.
REQ-025 ms_start with ms_amt == 0: out and carry unchanged; SHALL go directly to DONE, with busy never asserted.
REQ-026 In SHIFT, SHALL perform one single-bit shift per edge per latched dir/mode, with carry <= the bit shifted out, and decrement the remaining count.
REQ-027 After the edge performing the last shift, the FSM SHALL be in DONE: busy high exactly ms_amt cycles, then done high exactly 1 cycle.
REQ-028 Rotate SHALL feed the shifted-out bit into the vacated position.
REQ-029 ms_amt >= WIDTH SHALL perform all ms_amt shifts, with no modulo reduction.
REQ-030 Changes to ms_dir, ms_mode or ms_amt after acceptance SHALL NOT affect the shift in progress.
REQ-031 In SHIFT, cl SHALL abort: out <= 0, carry <= 0, state <= IDLE, and no done pulse.
REQ-032 In SHIFT, ld, inc, dec, sr, sl and ms_start SHALL be ignored.
REQ-033 DONE SHALL last one cycle, then return to IDLE unless a command in that cycle is ms_start, which SHALL be accepted per REQ-024/025.

Reset
REQ-034 rst high at an edge SHALL force out=0, carry=0, state IDLE (busy=0, done=0) and the internal count to 0, overriding all inputs, including mid-shift.
REQ-035 After reset, zero SHALL read 1.

Verification (WIDTH=8, AMT_W=4)
REQ-036 SAT=0: ld 0xA5, inc -> out 0xA6, carry 0; ld 0xFF, inc -> out 0x00, carry 1, zero 1.
REQ-037 SAT=1: ld 0x00, dec -> out 0x00, carry 1; ld 0xFF, inc -> out 0xFF, carry 1; ld 0x10, dec -> out 0x0F, carry 0.
REQ-038 ld 0x81; ms_start, dir 0, mode 01, amt 3 -> busy 3 cycles; out 0xC0, 0xE0, 0xF0; carry 1, 0, 0; then done for 1 cycle, then IDLE.
REQ-039 ld 0x81; ms_start, dir 1, mode 10, amt 9 -> busy 9 cycles; final out 0x03, carry 1; ld pulsed while busy is ignored.
REQ-040 ld 0x55; ms_start amt 5; cl in the 2nd busy cycle -> next edge: out 0x00, busy 0, no done pulse.
REQ-041 rst during SHIFT -> next edge: out 0, carry 0, busy 0, done 0; then ms_start amt 0 -> done 1 cycle later, busy never high, out unchanged.

Source files
------------

// File: rtl/param_shift_reg_if.sv
// Command/data bundle for param_shift_reg: the master drives commands and
// load data, the slave returns the register contents and status.
interface param_shift_reg_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
);
  logic             cl;
  logic             ld;
  logic             inc;
  logic             dec;
  logic [WIDTH-1:0] in;
  logic             sr;
  logic             ir;
  logic             sl;
  logic             il;
  logic             ms_start;
  logic             ms_dir;
  logic [1:0]       ms_mode;
  logic [AMT_W-1:0] ms_amt;
  logic [WIDTH-1:0] out;
  logic             carry;
  logic             zero;
  logic             busy;
  logic             done;

  modport master (
    output cl, ld, inc, dec, in, sr, ir, sl, il,
    output ms_start, ms_dir, ms_mode, ms_amt,
    input  out, carry, zero, busy, done
  );

  modport slave (
    input  cl, ld, inc, dec, in, sr, ir, sl, il,
    input  ms_start, ms_dir, ms_mode, ms_amt,
    output out, carry, zero, busy, done
  );
endinterface

// File: rtl/param_shift_reg.sv
// Parameterised register with clear/load/inc/dec, single-bit shifts and a
// multi-cycle shifter (logical / arithmetic / rotate) sequenced by a small FSM.
module param_shift_reg #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4,
  parameter bit SAT   = 1'b0
) (
  input logic               clk,
  input logic               rst,
  param_shift_reg_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_ARITH = 2'b01;
  localparam logic [1:0] MODE_ROT   = 2'b10;

  state_t           state;
  logic [WIDTH-1:0] data;
  logic             carry_q;
  logic [AMT_W-1:0] cnt;
  logic             dir_l;
  logic [1:0]       mode_l;

  // Returns {shifted-out bit, new value}; mode 11 falls into the logical case.
  function automatic logic [WIDTH:0] shift_one(input logic [WIDTH-1:0] v,
                                               input logic             dir,
                                               input logic [1:0]       mode);
    logic fill;
    if (dir) begin
      fill = (mode == MODE_ROT) ? v[WIDTH-1] : 1'b0;
      return {v[WIDTH-1], v[WIDTH-2:0], fill};
    end else begin
      case (mode)
        MODE_ARITH: fill = v[WIDTH-1];
        MODE_ROT:   fill = v[0];
        default:    fill = 1'b0;
      endcase
      return {v[0], fill, v[WIDTH-1:1]};
    end
  endfunction

  function automatic logic [WIDTH:0] inc_step(input logic [WIDTH-1:0] v);
    if (&v)
      return SAT ? {1'b1, v} : {1'b1, {WIDTH{1'b0}}};
    return {1'b0, v + WIDTH'(1)};
  endfunction

  function automatic logic [WIDTH:0] dec_step(input logic [WIDTH-1:0] v);
    if (~|v)
      return SAT ? {1'b1, v} : {1'b1, {WIDTH{1'b1}}};
    return {1'b0, v - WIDTH'(1)};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      data    <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      dir_l   <= 1'b0;
      mode_l  <= 2'b00;
    end else begin
      case (state)
        SHIFT: begin
          if (bus.cl) begin
            data    <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
            state   <= IDLE;
          end else begin
            {carry_q, data} <= shift_one(data, dir_l, mode_l);
            cnt             <= cnt - AMT_W'(1);
            if (cnt == AMT_W'(1))
              state <= DONE;
          end
        end
        default: begin
          // IDLE and DONE accept commands alike; DONE only lingers on a
          // zero-length multi-shift.
          state <= IDLE;
          if (bus.cl) begin
            data    <= '0;
            carry_q <= 1'b0;
          end else if (bus.ld) begin
            data    <= bus.in;
            carry_q <= 1'b0;
          end else if (bus.inc) begin
            {carry_q, data} <= inc_step(data);
          end else if (bus.dec) begin
            {carry_q, data} <= dec_step(data);
          end else if (bus.sr) begin
            data    <= {bus.ir, data[WIDTH-1:1]};
            carry_q <= data[0];
          end else if (bus.sl) begin
            data    <= {data[WIDTH-2:0], bus.il};
            carry_q <= data[WIDTH-1];
          end else if (bus.ms_start) begin
            if (bus.ms_amt != '0) begin
              dir_l  <= bus.ms_dir;
              mode_l <= bus.ms_mode;
              cnt    <= bus.ms_amt;
              state  <= SHIFT;
            end else begin
              state <= DONE;
            end
          end
        end
      endcase
    end
  end

  assign bus.out   = data;
  assign bus.carry = carry_q;
  assign bus.zero  = (data == '0);
  assign bus.busy  = (state == SHIFT);
  assign bus.done  = (state == DONE);

endmodule
